// File: rtl/alu_pkg.sv
// Shared opcode encoding and width for the 8-bit ALU slice.
package alu_pkg;
  localparam int ALU_W = 8;

  typedef enum logic [3:0] {
    ADD  = 4'b0000,
    SUB  = 4'b0001,
    AND  = 4'b0010,
    OR   = 4'b0011,
    NOT  = 4'b0100,
    XOR  = 4'b0101,
    SLL  = 4'b0110,
    SRL  = 4'b0111,
    SRA  = 4'b1000,
    SLT  = 4'b1001,
    SLTU = 4'b1010,
    ROL  = 4'b1011,
    ROR  = 4'b1100
  } alu_op_e;
endpackage

// File: rtl/alu_addsub_8.sv
// Combinational 8-bit adder/subtractor shared by ADD, SUB, SLT and SLTU.
// co is carry-out when adding and borrow (a<b unsigned) when subtracting.
module alu_addsub_8
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             sub,
  output logic [ALU_W-1:0] sum,
  output logic             co,
  output logic             ovf
);
  logic [ALU_W-1:0] b_eff;
  logic             cout;

  assign b_eff       = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, sub};
  // Two's-complement subtract produces carry = !borrow.
  assign co          = sub ? ~cout : cout;
  assign ovf         = (a[ALU_W-1] == b_eff[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
endmodule

// File: rtl/alu_8bits.sv
// 8-bit ALU with one-cycle registered result and flags.
// Optional ROL/ROR opcodes are enabled by defining ALU_ROTATE_EN.
module alu_8bits
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       aluop,
  output logic [WIDTH-1:0] alu_res,
  output logic             ZF,
  output logic             SF,
  output logic             OF,
  output logic             CF
);
  alu_op_e          op;
  logic             as_sub;
  logic [WIDTH-1:0] as_sum;
  logic             as_co;
  logic             as_ovf;
  logic [WIDTH-1:0] res;
  logic             of_n, cf_n, defined;

  assign op     = alu_op_e'(aluop);
  assign as_sub = (op == SUB) || (op == SLT) || (op == SLTU);

  alu_addsub_8 u_addsub (
    .a   (A),
    .b   (B),
    .sub (as_sub),
    .sum (as_sum),
    .co  (as_co),
    .ovf (as_ovf)
  );

`ifdef ALU_ROTATE_EN
  logic [2*WIDTH-1:0] rol_w, ror_w;
  assign rol_w = {A, A} << B[2:0];
  assign ror_w = {A, A} >> B[2:0];
`endif

  always_comb begin
    res     = '0;
    of_n    = 1'b0;
    cf_n    = 1'b0;
    defined = 1'b1;
    case (op)
      ADD:  begin res = as_sum; of_n = as_ovf; cf_n = as_co; end
      SUB:  begin res = as_sum; of_n = as_ovf; cf_n = as_co; end
      AND:  res = A & B;
      OR:   res = A | B;
      NOT:  res = ~A;
      XOR:  res = A ^ B;
      // Full 8-bit B is the shift amount, so B>=8 drains to zero/sign fill.
      SLL:  res = A << B;
      SRL:  res = A >> B;
      SRA:  res = WIDTH'($signed(A) >>> B);
      SLT:  res = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      SLTU: res = {{(WIDTH-1){1'b0}}, as_co};
`ifdef ALU_ROTATE_EN
      ROL:  res = rol_w[2*WIDTH-1:WIDTH];
      ROR:  res = ror_w[WIDTH-1:0];
`endif
      default: defined = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_res <= '0;
      ZF      <= 1'b0;
      SF      <= 1'b0;
      OF      <= 1'b0;
      CF      <= 1'b0;
    end else begin
      alu_res <= res;
      ZF      <= defined && (res == '0);
      SF      <= defined && res[WIDTH-1];
      OF      <= of_n;
      CF      <= cf_n;
    end
  end
endmodule

// File: tb/tb_alu_8bits.sv
// Scoreboard bench for alu_8bits: driver pushes model results, monitor pops and compares.
module tb_alu_8bits;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A, B;
  logic [3:0] aluop;
  logic [7:0] alu_res;
  logic       ZF, SF, OF, CF;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  alu_8bits dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .aluop(aluop),
    .alu_res(alu_res), .ZF(ZF), .SF(SF), .OF(OF), .CF(CF)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic straight from the opcode definitions.
  function automatic logic [11:0] model(bit r, int a, int b, int op);
    int sa, sb, t, st, res;
    bit z, s, o, c, def;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    res = 0; o = 0; c = 0; def = 1;
    case (op)
      0:  begin t = a + b; res = t % 256; c = (t > 255); st = sa + sb; o = (st > 127 || st < -128); end
      1:  begin t = a - b + 256; res = t % 256; c = (a < b); st = sa - sb; o = (st > 127 || st < -128); end
      2:  res = a & b;
      3:  res = a | b;
      4:  res = 255 - a;
      5:  res = a ^ b;
      6:  res = (b >= 8) ? 0 : (a * (1 << b)) % 256;
      7:  res = (b >= 8) ? 0 : a / (1 << b);
      8:  begin
            if (b >= 8) res = (sa < 0) ? 255 : 0;
            else begin
              st = sa;
              for (int i = 0; i < b; i++) st = (st < 0 && (st % 2 != 0)) ? (st - 1) / 2 : st / 2;
              res = (st + 256) % 256;
            end
          end
      9:  res = (sa < sb) ? 1 : 0;
      10: res = (a < b) ? 1 : 0;
`ifdef ALU_ROTATE_EN
      11: begin t = b % 8; res = ((a * (1 << t)) % 256) + a / (1 << (8 - t)); res = res % 256; end
      12: begin t = b % 8; res = (a / (1 << t)) + ((a * (1 << (8 - t))) % 256); res = res % 256; end
`endif
      default: def = 0;
    endcase
    if (!def) res = 0;
    z = def && (res == 0);
    s = def && (res >= 128);
    if (r) begin res = 0; z = 0; s = 0; o = 0; c = 0; end
    model = {res[7:0], z, s, o, c};
  endfunction

  task automatic issue(bit r, int a, int b, int op);
    @(negedge clk);
    rst = r; A = a[7:0]; B = b[7:0]; aluop = op[3:0];
    exp_q.push_back(model(r, a, b, op));
  endtask

  // Monitor: the DUT presents a new result every cycle, one edge after capture.
  initial begin
    logic [11:0] e, act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {alu_res, ZF, SF, OF, CF};
        n_cmp++;
        if (act !== e) begin
          n_err++;
          $display("FAIL alu_out cmp#%0d: got res=%02h Z%0b S%0b O%0b C%0b, want res=%02h Z%0b S%0b O%0b C%0b",
                   n_cmp, act[11:4], act[3], act[2], act[1], act[0], e[11:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; A = 8'h00; B = 8'h00; aluop = 4'h0;
    // Reset with nonzero held inputs, then release.
    issue(1, 'hA5, 'h3C, 0);
    issue(1, 'hA5, 'h3C, 0);
    issue(0, 'hA5, 'h3C, 0);
    // Directed corners.
    issue(0, 'h78, 'h07, 0);  issue(0, 'h78, 'h08, 0);  issue(0, 'h88, 'hF8, 0);
    issue(0, 'h88, 'hF7, 0);  issue(0, 'hFA, 'h06, 0);
    issue(0, 'h88, 'h08, 1);  issue(0, 'h88, 'h09, 1);  issue(0, 'h88, 'h88, 1);
    issue(0, 'hFA, 'hFB, 1);  issue(0, 'hFA, 'hF9, 1);
    issue(0, 'h78, 'h07, 2);  issue(0, 'h78, 'h08, 3);  issue(0, 'h88, 'h00, 4);
    issue(0, 'h88, 'hF7, 5);
    issue(0, 'h78, 3, 6);     issue(0, 'h78, 3, 7);     issue(0, 'h88, 3, 8);
    issue(0, 'h88, 9, 8);     issue(0, 'h78, 8, 6);     issue(0, 'h78, 200, 7);
    issue(0, 'h78, 'h08, 9);  issue(0, 'h88, 'hF8, 9);
    issue(0, 'hFA, 'hF9, 10); issue(0, 'hFA, 'hFB, 10);
    issue(0, 'h12, 'h34, 15); issue(0, 'h81, 1, 11);    issue(0, 'h81, 1, 12);
    // Mid-stream reset pulse.
    issue(1, 'hFF, 'hFF, 1);
    // Random traffic; bias shift amounts toward the interesting 0..10 range.
    for (int i = 0; i < 400; i++) begin
      int a, b, op;
      a  = $urandom_range(0, 255);
      op = $urandom_range(0, 15);
      b  = ((op >= 6 && op <= 8) || op == 11 || op == 12) && ($urandom_range(0, 3) != 0)
           ? $urandom_range(0, 10) : $urandom_range(0, 255);
      issue(0, a, b, op);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_8bits.md
Name: alu_8bits

Overview:
8-bit integer ALU with registered outputs. It performs add/sub, bitwise logic, shifts, and signed/unsigned compare. It also produces zero, sign, overflow and carry flags. It sits in the datapath as a single-cycle-latency execution unit; operands and opcode are sampled every clock.

Parameters:
WIDTH, 8, operand/result width. Only 8 is required to be supported; flags and shift rules below are written for 8.

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
A  input  8  operand A
B  input  8  operand B (shift amount for shift ops)
aluop  input  4  operation select
alu_res  output  8  registered result
ZF  output  1  zero flag, registered
SF  output  1  sign flag, registered
OF  output  1  signed-overflow flag, registered
CF  output  1  carry/borrow flag, registered

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- On a clk edge with rst=1: alu_res=0, ZF=0, SF=0, OF=0, CF=0.
- Otherwise, on every edge, register the combinational result of A, B and aluop. Latency is exactly 1 cycle. There is no handshake and no stall.
- Opcodes:
  - 0000 ADD: A+B mod 256.
  - 0001 SUB: A-B mod 256.
  - 0010 AND: A&B.
  - 0011 OR: A|B.
  - 0100 NOT: ~A (B ignored).
  - 0101 XOR: A^B.
  - 0110 SLL: A<<B.
  - 0111 SRL: A>>B, zero fill.
  - 1000 SRA: A>>>B, sign fill.
  - 1001 SLT: {7'b0, signed(A)<signed(B)}.
  - 1010 SLTU: {7'b0, A<B unsigned}.
  - 1011-1111: result 0, all flags 0 (unless ALU_ROTATE_EN is defined, see below).
- Shift amount is the full unsigned B:
  - B>=8 on SLL/SRL gives 0.
  - B>=8 on SRA gives 8{A[7]}.
- Flags:
  - ZF = (result==0) and SF = result[7], for every defined opcode.
  - ADD: CF = carry out of bit 7. OF = A[7]==B[7] && result[7]!=A[7].
  - SUB: CF = borrow = (A<B unsigned). OF = A[7]!=B[7] && result[7]!=A[7].
  - All other opcodes: OF=0, CF=0.

Optional Feature:
Macro ALU_ROTATE_EN.
- Defined: opcode 1011 ROL gives A rotated left by B[2:0]; opcode 1100 ROR gives A rotated right by B[2:0]. ZF and SF come from the result; OF=CF=0.
- Not defined: 1011 and 1100 behave like the other undefined opcodes (result 0, flags 0).
- Opcodes 1101-1111 are undefined in both cases.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e with ADD, SUB, AND, OR, NOT, XOR, SLL, SRL, SRA, SLT, SLTU, ROL, ROR;
  - localparam ALU_W=8.
- One sub-module, alu_addsub_8: a combinational adder/subtractor.
  - Inputs: a, b, sub.
  - Outputs: sum, carry-out/borrow, overflow.
  - It is shared by ADD, SUB, SLT and SLTU. Signed less-than = sum[7]^ovf; unsigned less-than = borrow.
- The top level holds the opcode mux and the output register.

Test Plan:
- Reset: assert rst for 2 cycles with nonzero inputs -> alu_res=0, all flags 0. Release rst -> the output matches the held inputs one cycle later.
- ADD:
  - 0x78+0x07 -> 0x7F, Z0 S0 O0 C0.
  - 0x78+0x08 -> 0x80, S1 O1 C0.
  - 0x88+0xF8 -> 0x80, S1 O0 C1.
  - 0x88+0xF7 -> 0x7F, O1 C1.
  - 0xFA+0x06 -> 0x00, Z1 C1 O0.
- SUB:
  - 0x88-0x08 -> 0x80, O0 C0.
  - 0x88-0x09 -> 0x7F, O1 C0.
  - 0x88-0x88 -> 0x00, Z1.
  - 0xFA-0xFB -> 0xFF, S1 C1.
  - 0xFA-0xF9 -> 0x01, C0.
- Logic:
  - AND 0x78,0x07 -> 0x00, Z1.
  - OR 0x78,0x08 -> 0x78.
  - NOT 0x88 -> 0x77.
  - XOR 0x88,0xF7 -> 0x7F.
  - All have O=C=0.
- Shifts:
  - SLL 0x78,3 -> 0xC0, S1.
  - SRL 0x78,3 -> 0x0F.
  - SRA 0x88,3 -> 0xF1.
  - SRA 0x88,9 -> 0xFF.
  - SLL 0x78,8 -> 0x00, Z1.
- Compare:
  - SLT 0x78,0x08 -> 0x00.
  - SLT 0x88,0xF8 -> 0x01.
  - SLTU 0xFA,0xF9 -> 0x00, Z1.
  - SLTU 0xFA,0xFB -> 0x01.
  - Opcode 1111 -> 0x00, flags 0.
  - With ALU_ROTATE_EN: ROL 0x81,1 -> 0x03.
